i_cache: RTL and testbench
==========================

// Module: i_cache
// PURPOSE
//  Direct-mapped instruction cache between the IF stage and mem_control.
//  Hits return a word one cycle after acceptance. Misses issue a single
//  32-bit fetch to mem_control via inst_needed/inst_addr_o, fill the line,
//  and forward the word. A branch_interception abandons an outstanding miss.
// PARAMETERS
//  INDEX_BITS  7   log2(number of lines); one 32-bit word per line
//  ADDR_WIDTH  32  address width
// PORTS
//  clk               in   1   clock
//  rst               in   1   reset, synchronous, active-high
//  branch_interception in 1   squash current fetch (same wire as mem_control)
//  if_req            in   1   IF requests the word at if_addr
//  if_addr           in   32  fetch address; [1:0] ignored
//  if_inst           out  32  fetched instruction, valid when if_valid
//  if_valid          out  1   one-cycle pulse: if_inst is the word for the accepted request
//  inst_needed       out  1   miss request to mem_control
//  inst_addr_o       out  32  miss address, word aligned ({addr[31:2],2'b00})
//  inst_i            in   32  word returned by mem_control
//  inst_available    in   1   inst_i valid this cycle
// BEHAVIOUR
//  Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
//  Storage: data[2^INDEX_BITS] x 32, tag array, valid[2^INDEX_BITS].
//  Reset: all valid bits 0; if_valid=0, if_inst=0, inst_needed=0,
//   inst_addr_o=0; state=IDLE. Reset mid-miss behaves identically: the miss
//   is dropped and no fill occurs.
//  FSM states: IDLE, MISS.
//  IDLE: accepts a request when if_req=1, if_valid=0 and branch_interception=0.
//   No request is accepted in the cycle if_valid=1 (one bubble). IF must
//   change or drop if_addr in that cycle.
//   Hit (valid & tag match): next edge if_valid=1, if_inst=data[index].
//   Stay in IDLE.
//   Miss: latch the address. Next edge inst_needed=1, inst_addr_o=aligned
//   address, go to MISS.
//  MISS: inst_needed and inst_addr_o are held stable until inst_available.
//   Changes on if_req/if_addr are ignored.
//   inst_available=1 and branch_interception=0:
//    - write data/tag and set valid for the latched index;
//    - next edge if_valid=1, if_inst=inst_i, inst_needed=0; go to IDLE.
//   branch_interception=1 and inst_available=0:
//    - next edge inst_needed=0, no fill, no if_valid; go to IDLE.
//   branch_interception=1 and inst_available=1 in the same cycle:
//    - fill the line, since the data is correct for the latched address;
//    - if_valid stays 0; go to IDLE.
//  branch_interception in IDLE: no acceptance that cycle; an if_valid already
//   scheduled for that edge is suppressed.
//  if_valid is high for exactly one cycle per delivered word. if_inst holds
//   its last value otherwise.
//  Write-never: the cache does not snoop data-side stores (no self-modifying
//   code support).
//  Latency:
//   hit = 1 cycle accept->if_valid; hit throughput = 1 word per 2 cycles;
//   miss = 1 + mem_control latency + 1.
// TESTING
//  T1 cold miss:
//   rst, then if_req addr 0x0000_0000 -> inst_needed=1, inst_addr_o=0.
//   Return inst_i=0x0000_0013 -> if_valid pulse, if_inst=0x13.
//  T2 hit:
//   re-request 0x0 -> if_valid one cycle after acceptance, inst_needed stays 0.
//  T3 conflict:
//   fill 0x0 (0x13), then request 0x200 (same index, tag differs) -> miss.
//   Fill 0x0000_00B3. Request 0x0 again -> miss (evicted).
//  T4 squash:
//   miss on 0x1004, assert branch_interception before inst_available ->
//   inst_needed=0 next cycle, no if_valid. Later request 0x1004 -> miss again.
//  T5 collision:
//   branch_interception and inst_available same cycle on miss 0x2008 ->
//   no if_valid. Later request 0x2008 -> hit, no inst_needed.
//  T6 reset mid-miss:
//   assert rst while inst_needed=1 -> all outputs 0. Previously filled
//   address 0x0 now misses.

Source files
------------

// File: rtl/i_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line, sitting between IF and mem_control.
// Hits answer one cycle after acceptance; misses fetch a single word, fill the line and forward it.
module i_cache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_interception,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_inst,
    output logic                  if_valid,
    output logic                  inst_needed,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    input  logic [31:0]           inst_i,
    input  logic                  inst_available
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             if_inst_q, if_inst_d;
    logic                    if_valid_q, if_valid_d;
    logic                    inst_needed_q, inst_needed_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic [LINES-1:0]        valid_q, valid_d;

    logic [31:0]             data_mem [LINES];
    logic [TAG_BITS-1:0]     tag_mem  [LINES];

    logic [INDEX_BITS-1:0]   req_index, miss_index;
    logic [TAG_BITS-1:0]     req_tag, miss_tag;
    logic                    accept, hit, fill_en;

    assign req_index  = if_addr[INDEX_BITS+1:2];
    assign req_tag    = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign miss_index = miss_addr_q[INDEX_BITS+1:2];
    assign miss_tag   = miss_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

    // The cycle after a delivered word is a forced bubble, so if_valid_q blocks acceptance.
    assign accept  = (state_q == IDLE) && if_req && !if_valid_q && !branch_interception;
    assign hit     = valid_q[req_index] && (tag_mem[req_index] == req_tag);
    // Returned data is correct for the latched address even when squashed, so it always fills.
    assign fill_en = (state_q == MISS) && inst_available;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !hit) state_d = MISS;
            MISS: if (inst_available || branch_interception) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_valid_d    = 1'b0;
        if_inst_d     = if_inst_q;
        inst_needed_d = inst_needed_q;
        miss_addr_d   = miss_addr_q;
        valid_d       = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_mem[req_index];
                    end else begin
                        inst_needed_d = 1'b1;
                        miss_addr_d   = if_addr & ~ADDR_WIDTH'(3);
                    end
                end
            end
            MISS: begin
                if (inst_available || branch_interception) inst_needed_d = 1'b0;
                if (inst_available && !branch_interception) begin
                    if_valid_d = 1'b1;
                    if_inst_d  = inst_i;
                end
                if (fill_en) valid_d[miss_index] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_q     <= '0;
            if_valid_q    <= 1'b0;
            inst_needed_q <= 1'b0;
            miss_addr_q   <= '0;
            valid_q       <= '0;
        end else begin
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
            inst_needed_q <= inst_needed_d;
            miss_addr_q   <= miss_addr_d;
            valid_q       <= valid_d;
        end
    end

    // Line storage has no reset; the valid vector alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            data_mem[miss_index] <= inst_i;
            tag_mem[miss_index]  <= miss_tag;
        end
    end

    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;
    assign inst_needed = inst_needed_q;
    assign inst_addr_o = miss_addr_q;

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed scenarios followed by randomized fetches,
// checked against a line-level model of which word address each index currently holds.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_interception;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        inst_needed;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic        inst_available;

    int compared   = 0;
    int mismatched = 0;

    // Model: per index, the word address resident and its data.
    logic [29:0] line_addr [int];
    logic [31:0] line_data [int];

    i_cache dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch_interception (branch_interception),
        .if_req              (if_req),
        .if_addr             (if_addr),
        .if_inst             (if_inst),
        .if_valid            (if_valid),
        .inst_needed         (inst_needed),
        .inst_addr_o         (inst_addr_o),
        .inst_i              (inst_i),
        .inst_available      (inst_available)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return line_addr.exists(idx_of(a)) && (line_addr[idx_of(a)] == a[31:2]);
    endfunction

    // squash: 0 = normal return, 1 = branch before data, 2 = branch and data together
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                         input int lat, input int squash);
        bit exp_hit;
        logic [31:0] exp_word;
        exp_hit = model_hit(addr);
        if_req  = 1'b1;
        if_addr = addr;
        tick();
        if_req = 1'b0;
        if (exp_hit) begin
            exp_word = line_data[idx_of(addr)];
            check("hit_valid", if_valid, 1);
            check("hit_inst", if_inst, exp_word);
            check("hit_no_need", inst_needed, 0);
            tick();
            check("hit_pulse_end", if_valid, 0);
            $display("fetch %h hit  -> %h", addr, exp_word);
        end else begin
            check("miss_valid", if_valid, 0);
            check("miss_need", inst_needed, 1);
            check("miss_addr", inst_addr_o, addr & 32'hFFFF_FFFC);
            for (int i = 0; i < lat; i++) begin
                if_req  = 1'($urandom);
                if_addr = $urandom;
                tick();
                check("miss_hold_need", inst_needed, 1);
                check("miss_hold_addr", inst_addr_o, addr & 32'hFFFF_FFFC);
                check("miss_hold_valid", if_valid, 0);
            end
            if_req              = 1'b0;
            inst_i              = word;
            inst_available      = (squash != 1);
            branch_interception = (squash != 0);
            tick();
            inst_available      = 1'b0;
            branch_interception = 1'b0;
            if (squash != 1) begin
                line_addr[idx_of(addr)] = addr[31:2];
                line_data[idx_of(addr)] = word;
            end
            check("ret_need", inst_needed, 0);
            check("ret_valid", if_valid, (squash == 0) ? 32'd1 : 32'd0);
            if (squash == 0) check("ret_inst", if_inst, word);
            tick();
            check("ret_pulse_end", if_valid, 0);
            $display("fetch %h miss lat=%0d squash=%0d word=%h", addr, lat, squash, word);
        end
    endtask

    task automatic idle_branch(input logic [31:0] addr);
        if_req              = 1'b1;
        if_addr             = addr;
        branch_interception = 1'b1;
        tick();
        if_req              = 1'b0;
        branch_interception = 1'b0;
        check("bi_idle_valid", if_valid, 0);
        check("bi_idle_need", inst_needed, 0);
        $display("branch in idle with request %h", addr);
    endtask

    initial begin
        rst                 = 1'b1;
        branch_interception = 1'b0;
        if_req              = 1'b0;
        if_addr             = '0;
        inst_i              = '0;
        inst_available      = 1'b0;
        tick();
        tick();
        check("rst_valid", if_valid, 0);
        check("rst_inst", if_inst, 0);
        check("rst_need", inst_needed, 0);
        check("rst_addr", inst_addr_o, 0);
        rst = 1'b0;
        $display("reset released");

        // T1 cold miss, T2 hit
        fetch(32'h0000_0000, 32'h0000_0013, 2, 0);
        fetch(32'h0000_0000, 32'hDEAD_BEEF, 0, 0);

        // Held request on a hit: bubble cycle between deliveries
        if_req  = 1'b1;
        if_addr = 32'h0000_0002;
        tick();
        check("tput_first", if_valid, 1);
        tick();
        check("tput_bubble", if_valid, 0);
        tick();
        check("tput_second", if_valid, 1);
        check("tput_inst", if_inst, 32'h0000_0013);
        if_req = 1'b0;
        tick();
        check("tput_end", if_valid, 0);
        $display("held request throughput");

        // T3 conflict eviction
        fetch(32'h0000_0200, 32'h0000_00B3, 1, 0);
        fetch(32'h0000_0000, 32'h0000_0013, 3, 0);

        // T4 squash before data
        fetch(32'h0000_1004, 32'h1111_1111, 2, 1);
        fetch(32'h0000_1004, 32'h2222_2222, 1, 0);

        // T5 squash and data together fills the line
        fetch(32'h0000_2008, 32'h3333_3333, 1, 2);
        fetch(32'h0000_2008, 32'h0, 0, 0);
        idle_branch(32'h0000_2008);

        // T6 reset mid-miss, with data arriving during reset
        if_req  = 1'b1;
        if_addr = 32'h0000_4010;
        tick();
        if_req = 1'b0;
        check("t6_need", inst_needed, 1);
        rst            = 1'b1;
        inst_available = 1'b1;
        inst_i         = 32'hBAD0_BAD0;
        tick();
        rst            = 1'b0;
        inst_available = 1'b0;
        check("t6_valid", if_valid, 0);
        check("t6_inst", if_inst, 0);
        check("t6_need0", inst_needed, 0);
        check("t6_addr", inst_addr_o, 0);
        line_addr.delete();
        line_data.delete();
        $display("reset mid-miss");
        check("t6_model_miss", 32'(model_hit(32'h0)), 0);
        fetch(32'h0000_0000, 32'h0000_0013, 1, 0);
        fetch(32'h0000_4010, 32'h4444_4444, 0, 0);
        fetch(32'h0000_4010, 32'h0, 0, 0);

        // Randomized traffic over a small footprint to force hits and conflicts
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            int r;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 8) begin
                idle_branch(a);
            end else begin
                fetch(a, $urandom, $urandom_range(0, 4), (r < 16) ? 1 : ((r < 22) ? 2 : 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
